// File: rtl/warp_branch_stack.sv
// Per-warp PC, active mask and divergence stack for the fetcher; blocks fetch while a branch is unresolved.
// Latency: every input pulse is registered and is visible on the outputs one cycle later. No input-to-output paths.
// Backpressure: none. Pulses are single-cycle and are always consumed. Illegal events are ignored and are flagged in simulation.
module warp_branch_stack #(
  parameter int NumWarps   = 8,
  parameter int WarpWidth  = 4,
  parameter int PcWidth    = 16,
  parameter int StackDepth = 4,
  localparam int WidWidth  = NumWarps > 1 ? $clog2(NumWarps) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          init_i,
  input  logic [PcWidth-1:0]            init_pc_i,
  input  logic                          fetch_i,
  input  logic [WidWidth-1:0]           fetch_wid_i,
  input  logic                          dec_branch_i,
  input  logic [WidWidth-1:0]           dec_branch_wid_i,
  input  logic                          dec_stop_i,
  input  logic [WidWidth-1:0]           dec_stop_wid_i,
  input  logic                          bru_branch_i,
  input  logic [WidWidth-1:0]           bru_branch_wid_i,
  input  logic [WarpWidth-1:0]          bru_branching_mask_i,
  input  logic [PcWidth-1:0]            bru_branch_pc_i,
  output logic [NumWarps-1:0]           warp_ready_o,
  output logic [NumWarps*PcWidth-1:0]   warp_pc_o,
  output logic [NumWarps*WarpWidth-1:0] warp_act_mask_o,
  output logic                          all_done_o,
  output logic                          overflow_o
);

  localparam int SpWidth  = $clog2(StackDepth + 1);
  localparam int IdxWidth = StackDepth > 1 ? $clog2(StackDepth) : 1;

  typedef enum logic [1:0] {IDLE, READY, WAIT_BR, DONE} warp_state_e;

  warp_state_e          state_q [NumWarps];
  warp_state_e          state_d [NumWarps];
  logic [PcWidth-1:0]   pc_q    [NumWarps];
  logic [PcWidth-1:0]   pc_d    [NumWarps];
  logic [WarpWidth-1:0] mask_q  [NumWarps];
  logic [WarpWidth-1:0] mask_d  [NumWarps];
  logic [SpWidth-1:0]   sp_q    [NumWarps];
  logic [SpWidth-1:0]   sp_d    [NumWarps];
  logic [PcWidth-1:0]   stk_pc_q   [NumWarps][StackDepth];
  logic [WarpWidth-1:0] stk_mask_q [NumWarps][StackDepth];
  logic [WarpWidth-1:0] taken     [NumWarps];
  logic [WarpWidth-1:0] not_taken [NumWarps];
  logic [NumWarps-1:0]  push;
  logic                 overflow_q, overflow_d;

  // Split each warp's active mask into the taken and fall-through thread sets.
  always_comb begin
    for (int w = 0; w < NumWarps; w++) begin
      taken[w]     = bru_branching_mask_i & mask_q[w];
      not_taken[w] = mask_q[w] & ~bru_branching_mask_i;
    end
  end

  // Next-state logic. A stop wins over a resolution for the same warp; init wins over everything.
  always_comb begin
    overflow_d = overflow_q;
    push       = '0;
    for (int w = 0; w < NumWarps; w++) begin
      state_d[w] = state_q[w];
      pc_d[w]    = pc_q[w];
      mask_d[w]  = mask_q[w];
      sp_d[w]    = sp_q[w];
      if (init_i) begin
        state_d[w] = READY;
        pc_d[w]    = init_pc_i;
        mask_d[w]  = '1;
        sp_d[w]    = '0;
      end else begin
        if (state_q[w] == READY) begin
          if (fetch_i && fetch_wid_i == WidWidth'(w))           pc_d[w]    = pc_q[w] + 1'b1;
          if (dec_branch_i && dec_branch_wid_i == WidWidth'(w)) state_d[w] = WAIT_BR;
        end
        if (dec_stop_i && dec_stop_wid_i == WidWidth'(w) &&
            (state_q[w] == READY || state_q[w] == WAIT_BR)) begin
          if (sp_q[w] != '0) begin
            // Resume the most recently deferred fall-through path.
            pc_d[w]    = stk_pc_q[w][IdxWidth'(sp_q[w] - 1'b1)];
            mask_d[w]  = stk_mask_q[w][IdxWidth'(sp_q[w] - 1'b1)];
            sp_d[w]    = sp_q[w] - 1'b1;
            state_d[w] = READY;
          end else begin
            state_d[w] = DONE;
            mask_d[w]  = '0;
          end
        end else if (bru_branch_i && bru_branch_wid_i == WidWidth'(w) && state_q[w] == WAIT_BR) begin
          state_d[w] = READY;
          if (taken[w] == '0) begin
            pc_d[w] = pc_q[w];
          end else if (not_taken[w] == '0) begin
            pc_d[w] = bru_branch_pc_i;
          end else begin
            pc_d[w]   = bru_branch_pc_i;
            mask_d[w] = taken[w];
            // With no room left the fall-through threads are lost; the sticky flag records it.
            if (sp_q[w] == SpWidth'(StackDepth)) begin
              overflow_d = 1'b1;
            end else begin
              push[w] = 1'b1;
              sp_d[w] = sp_q[w] + 1'b1;
            end
          end
        end
      end
    end
  end

  // Per-warp state, PC, mask and stack pointer registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      overflow_q <= 1'b0;
      for (int w = 0; w < NumWarps; w++) begin
        state_q[w] <= IDLE;
        pc_q[w]    <= '0;
        mask_q[w]  <= '0;
        sp_q[w]    <= '0;
      end
    end else begin
      overflow_q <= overflow_d;
      for (int w = 0; w < NumWarps; w++) begin
        state_q[w] <= state_d[w];
        pc_q[w]    <= pc_d[w];
        mask_q[w]  <= mask_d[w];
        sp_q[w]    <= sp_d[w];
      end
    end
  end

  // Stack storage: the pointer alone defines validity, so the entries need no reset.
  always_ff @(posedge clk_i) begin
    for (int w = 0; w < NumWarps; w++) begin
      if (push[w]) begin
        stk_pc_q[w][IdxWidth'(sp_q[w])]   <= pc_q[w];
        stk_mask_q[w][IdxWidth'(sp_q[w])] <= not_taken[w];
      end
    end
  end

  // Flatten per-warp state onto the output buses.
  always_comb begin
    all_done_o = 1'b1;
    overflow_o = overflow_q;
    for (int w = 0; w < NumWarps; w++) begin
      warp_ready_o[w]                           = (state_q[w] == READY);
      warp_pc_o[w*PcWidth +: PcWidth]           = pc_q[w];
      warp_act_mask_o[w*WarpWidth +: WarpWidth] = mask_q[w];
      all_done_o                                = all_done_o & (state_q[w] == DONE);
    end
  end

`ifndef SYNTHESIS
  // Flag events that the control flow ignores because the warp is in the wrong state.
  always @(posedge clk_i) begin
    if (rst_ni && !init_i) begin
      if (fetch_i) a_fetch_ready: assert (state_q[fetch_wid_i] == READY);
      if (bru_branch_i) a_bru_wait: assert (state_q[bru_branch_wid_i] == WAIT_BR);
      if (bru_branch_i && dec_stop_i) a_stop_bru: assert (bru_branch_wid_i != dec_stop_wid_i);
    end
  end
`endif

endmodule
